// File: rtl/cell_selector.sv
`default_nettype none
// ============================================================================
// Module      : cell_selector
// Description : 3x3 board cursor driven by debounced push-buttons; issues a
//               fixed-length write strobe when placing on a free cell.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_selector #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PULSE_CYCLES    = 4,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    input  logic [8:0] occupied,
    output logic [8:0] C,
    output logic       writeEn,
    output logic       place_reject,
    output logic       cursor_blink
);

    localparam int NBTN      = 5;
    localparam int BTN_PLACE = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 4;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int PW  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int BW  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] level;
    logic [NBTN-1:0] level_d;
    logic [NBTN-1:0] armed;
    logic [NBTN-1:0] edges;
    logic [1:0]      sync_valid;

    assign raw = {btn_right, btn_left, btn_down, btn_up, btn_place};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            sync_valid <= '0;
            level_d    <= '0;
            armed      <= '0;
            edges      <= '0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            sync_valid <= {sync_valid[0], 1'b1};
            level_d    <= level;
            // A button only arms once it has been seen released after reset,
            // so a button held through reset cannot fire.
            armed      <= armed | ({NBTN{sync_valid[1]}} & ~sync2 & ~level);
            edges      <= level & ~level_d & armed;
        end
    end

    generate
        for (genvar i = 0; i < NBTN; i++) begin : g_btn
            logic [DBW-1:0] cnt;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt      <= '0;
                    level[i] <= 1'b0;
                end else if (sync2[i] != level[i]) begin
                    if (cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                        cnt      <= '0;
                        level[i] <= sync2[i];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    endgenerate

    state_t         state;
    state_t         state_n;
    logic [3:0]     idx;
    logic [3:0]     idx_n;
    logic [3:0]     row;
    logic [3:0]     col;
    logic [PW-1:0]  pcnt;
    logic [PW-1:0]  pcnt_n;
    logic           reject_n;
    logic           move;
    logic [BW-1:0]  bcnt;

    assign row = idx / 4'd3;
    assign col = idx % 4'd3;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= 4'd4;
            pcnt         <= '0;
            place_reject <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            pcnt         <= pcnt_n;
            place_reject <= reject_n;
        end
    end

    // Priority: place > up > down > left > right; lower ones are dropped.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        pcnt_n   = pcnt;
        reject_n = 1'b0;
        move     = 1'b0;
        case (state)
            IDLE: begin
                if (edges[BTN_PLACE]) begin
                    if (occupied[idx]) begin
                        reject_n = 1'b1;
                    end else begin
                        state_n = PULSE;
                        pcnt_n  = '0;
                    end
                end else if (edges[BTN_UP]) begin
                    idx_n = (row == 4'd0) ? idx + 4'd6 : idx - 4'd3;
                    move  = 1'b1;
                end else if (edges[BTN_DOWN]) begin
                    idx_n = (row == 4'd2) ? idx - 4'd6 : idx + 4'd3;
                    move  = 1'b1;
                end else if (edges[BTN_LEFT]) begin
                    idx_n = (col == 4'd0) ? idx + 4'd2 : idx - 4'd1;
                    move  = 1'b1;
                end else if (edges[BTN_RIGHT]) begin
                    idx_n = (col == 4'd2) ? idx - 4'd2 : idx + 4'd1;
                    move  = 1'b1;
                end
            end
            PULSE: begin
                if (pcnt == PW'(PULSE_CYCLES - 1)) begin
                    state_n = RELEASE;
                end else begin
                    pcnt_n = pcnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!level[BTN_PLACE]) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign writeEn = (state == PULSE);
    assign C       = 9'd1 << idx;

    always_ff @(posedge clk) begin
        if (reset || move) begin
            bcnt         <= '0;
            cursor_blink <= 1'b0;
        end else if (bcnt == BW'(BLINK_CYCLES - 1)) begin
            bcnt         <= '0;
            cursor_blink <= ~cursor_blink;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cell_selector.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_selector
// Description : Directed self-checking bench for cell_selector (D=4, P=4, B=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_selector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_place = 1'b0;
    logic [8:0] occupied = 9'd0;
    logic [8:0] C;
    logic       writeEn;
    logic       place_reject;
    logic       cursor_blink;

    int total = 0;
    int bad   = 0;

    cell_selector #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (4),
        .BLINK_CYCLES   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_place   (btn_place),
        .occupied    (occupied),
        .C           (C),
        .writeEn     (writeEn),
        .place_reject(place_reject),
        .cursor_blink(cursor_blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_place = v;
            1: btn_up    = v;
            2: btn_down  = v;
            3: btn_left  = v;
            default: btn_right = v;
        endcase
    endtask

    // Press at a negedge; returns at the negedge just after the action edge
    // (the 8th rising edge counting the first sampling edge as 1st).
    task automatic press(input int b);
        @(negedge clk);
        set_btn(b, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_btn(input int b);
        @(negedge clk);
        set_btn(b, 1'b0);
        repeat (12) @(negedge clk);
    endtask

    int hits;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_C", C, 9'b000010000);
        check("reset_writeEn", {8'd0, writeEn}, 9'd0);
        check("reset_reject", {8'd0, place_reject}, 9'd0);
        check("reset_blink", {8'd0, cursor_blink}, 9'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Right: exact latency of 7 cycles after the first sampling edge
        @(negedge clk);
        btn_right = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("right_early", C, 9'b000010000);
        @(posedge clk);
        @(negedge clk);
        check("right_on_time", C, 9'b000100000);
        repeat (100) @(negedge clk);
        check("right_no_repeat", C, 9'b000100000);
        release_btn(4);

        // Wrap cases
        press(4); release_btn(4);
        check("wrap_right_5_3", C, 9'b000001000);
        press(1); release_btn(1);
        check("up_3_0", C, 9'b000000001);
        press(4); release_btn(4);
        check("right_0_1", C, 9'b000000010);
        press(1); release_btn(1);
        check("wrap_up_1_7", C, 9'b010000000);
        press(4); release_btn(4);
        check("right_7_8", C, 9'b100000000);
        press(2); release_btn(2);
        check("wrap_down_8_2", C, 9'b000000100);

        // Left move plus blink restart and first toggle
        press(3);
        check("left_2_1", C, 9'b000000010);
        check("blink_restart", {8'd0, cursor_blink}, 9'd0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("blink_still_low", {8'd0, cursor_blink}, 9'd0);
        @(posedge clk);
        @(negedge clk);
        check("blink_toggle", {8'd0, cursor_blink}, 9'd1);
        release_btn(3);

        // Bouncing left never settles
        for (int i = 0; i < 20; i++) begin
            btn_left = ~btn_left;
            repeat (2) @(negedge clk);
        end
        btn_left = 1'b0;
        repeat (12) @(negedge clk);
        check("bounce_no_move", C, 9'b000000010);

        press(2); release_btn(2);
        check("down_1_4", C, 9'b000010000);

        // Placement on a free cell
        occupied = 9'd0;
        press(0);
        for (int i = 0; i < 4; i++) begin
            check("place_we_high", {8'd0, writeEn}, 9'd1);
            check("place_C_frozen", C, 9'b000010000);
            occupied = 9'b000010000;
            @(negedge clk);
        end
        check("place_we_low", {8'd0, writeEn}, 9'd0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (writeEn) hits++;
        end
        check("held_place_nothing", 9'(hits), 9'd0);
        release_btn(0);

        // Placement on an occupied cell
        occupied = 9'b000010000;
        press(0);
        check("reject_pulse", {8'd0, place_reject}, 9'd1);
        check("reject_we", {8'd0, writeEn}, 9'd0);
        @(negedge clk);
        check("reject_one_cycle", {8'd0, place_reject}, 9'd0);
        release_btn(0);
        check("reject_C", C, 9'b000010000);

        // Up and place together: only the placement
        occupied = 9'd0;
        @(negedge clk);
        btn_up    = 1'b1;
        btn_place = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("prio_we", {8'd0, writeEn}, 9'd1);
        check("prio_C", C, 9'b000010000);
        btn_up    = 1'b0;
        btn_place = 1'b0;
        repeat (14) @(negedge clk);
        check("prio_no_move", C, 9'b000010000);

        // Reset during the second PULSE cycle with place held through it
        press(0);
        check("pre_reset_we", {8'd0, writeEn}, 9'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_we", {8'd0, writeEn}, 9'd0);
        check("reset_mid_C", C, 9'b000010000);
        reset = 1'b0;
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (writeEn || place_reject) hits++;
        end
        check("held_through_reset", 9'(hits), 9'd0);
        release_btn(0);

        // Back in IDLE: moves and placements work again
        press(4); release_btn(4);
        check("post_reset_right", C, 9'b000100000);
        press(0);
        check("post_reset_place", {8'd0, writeEn}, 9'd1);
        release_btn(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cell_selector.md
CELL_SELECTOR -- requirements
Module: cell_selector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, consecutive stable synchronized cycles required before a button level is accepted.
REQ-002 Parameter PULSE_CYCLES, default 4, number of cycles writeEn is held high per placement.
REQ-003 Parameter BLINK_CYCLES, default 12500000, half-period of cursor_blink in clk cycles.
REQ-004 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_up, btn_down, btn_left, btn_right, btn_place  input  1 each  raw asynchronous push-buttons, active-high.
REQ-007 occupied  input  9  current board occupancy (X|O), bit i = cell i, row-major, cell 0 top-left.
REQ-008 C  output  9  one-hot selected cell, bit index = cursor index.
REQ-009 writeEn  output  1  placement strobe to the game model.
REQ-010 place_reject  output  1  one-cycle pulse when placement is refused.
REQ-011 cursor_blink  output  1  square wave for cursor highlighting.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a per-button debounce counter; debounced level SHALL change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL clear that counter.
REQ-013 An action SHALL fire on the rising edge of a debounced level only; held buttons SHALL NOT auto-repeat.
REQ-014 Total latency, raw button first sampled high (stable) to cursor/writeEn change, SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-015 Cursor index SHALL be 0..8 (row = idx/3, col = idx%3); C SHALL equal 1<<idx at all times and never be zero or multi-hot.
REQ-016 Right: col 2 wraps to col 0 same row; left: col 0 wraps to col 2; down: row 2 wraps to row 0; up: row 0 wraps to row 2; column/row otherwise unchanged.
REQ-017 Simultaneous action edges in one cycle: only the highest priority SHALL execute: place > up > down > left > right; the others SHALL be discarded.
REQ-018 FSM states IDLE, PULSE, RELEASE.
REQ-019 IDLE: move edges update cursor; place edge with occupied[idx]=0 -> PULSE, writeEn=1 next cycle; place edge with occupied[idx]=1 -> place_reject=1 for one cycle, stay IDLE, cursor unchanged.
REQ-020 PULSE: writeEn high for exactly PULSE_CYCLES cycles; C frozen; all button edges ignored; then -> RELEASE with writeEn=0.
REQ-021 RELEASE: writeEn=0; move edges ignored; -> IDLE on the first cycle debounced btn_place is low (guarantees writeEn low for at least one cycle between placements).
REQ-022 occupied changing during PULSE/RELEASE SHALL NOT affect writeEn or C.
REQ-023 cursor_blink SHALL toggle every BLINK_CYCLES cycles from a free-running counter; it SHALL restart at 0 (output low) on any cursor move.

Reset
REQ-024 On reset: idx=4, C=9'b000010000, writeEn=0, place_reject=0, cursor_blink=0, state IDLE, all synchronizers, debounced levels and counters 0.
REQ-025 Reset asserted mid-PULSE SHALL drop writeEn to 0 on the next edge with no further strobe; a button held through reset deassertion SHALL NOT generate an action until released and re-pressed.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=4, BLINK_CYCLES=8)
REQ-026 Reset, then btn_right held clean -> C becomes 9'b000100000 exactly 7 cycles after first sample; held 100 cycles -> no further move.
REQ-027 From idx 5, right -> idx 3; from idx 1, up -> idx 7; from idx 8, down -> idx 2.
REQ-028 btn_left toggled every 2 cycles for 40 cycles then low -> C unchanged, no action.
REQ-029 occupied=0, place at idx 4 -> writeEn high 4 cycles with C=9'b000010000, then low; second place press while still held gives nothing until released.
REQ-030 occupied=9'b000010000, place at idx 4 -> place_reject one cycle, writeEn stays 0; up and place rising same cycle -> only placement occurs.
REQ-031 Reset asserted in 2nd PULSE cycle -> writeEn 0 next edge, C=9'b000010000, state IDLE.
